// File: rtl/wb8_pkg.sv
// Shared types and helpers for the Wishbone-8 address interconnect.
// Holds the FSM encoding, the error read-data default and the address matcher.
package wb8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERRACK = 2'd2
    } wb8_state_e;

    localparam logic [7:0] ERR_DATA_DEF = 8'hFF;

    function automatic logic slave_match(
        input logic [31:0] adr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/wb8_addr_decode.sv
// Fixed-priority BASE/MASK address decoder: lowest matching index wins.
// Falls back to DEFAULT_SLAVE; DEFAULT_SLAVE == NSLAVES marks the address unmapped.
module wb8_addr_decode
    import wb8_pkg::*;
#(
    parameter int                    NSLAVES       = 8,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = {NSLAVES{32'h0}},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = {NSLAVES{32'h0}},
    parameter int                    DEFAULT_SLAVE = NSLAVES - 1,
    parameter int                    IW            = $clog2(NSLAVES + 1)
) (
    input  logic [31:0]   i_adr,
    output logic [IW-1:0] o_dec,
    output logic          o_mapped
);

    logic w_hit;

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        w_hit = 1'b0;
        o_dec = IW'(DEFAULT_SLAVE);
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (slave_match(i_adr, SLAVE_BASE[32*i +: 32],
                            SLAVE_MASK[32*i +: 32])) begin
                o_dec = IW'(i);
                w_hit = 1'b1;
            end
        end
    end

    assign o_mapped = w_hit || (DEFAULT_SLAVE < NSLAVES);

endmodule

// File: rtl/wb8_interconnect.sv
// Registered Wishbone-8 interconnect: decodes the master onto NSLAVES channels,
// latches the route per transaction, and terminates hung/unmapped cycles.
module wb8_interconnect
    import wb8_pkg::*;
#(
    parameter int                    NSLAVES       = 8,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = {NSLAVES{32'h0}},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = {NSLAVES{32'h0}},
    parameter int                    DEFAULT_SLAVE = NSLAVES - 1,
    parameter int                    TIMEOUT       = 255,
    parameter logic [7:0]            ERR_DATA      = ERR_DATA_DEF
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [31:0]          M_ADR_I,
    input  logic                 M_CYC_I,
    input  logic                 M_STB_I,
    output logic [7:0]           M_DAT_O,
    output logic                 M_ACK_O,
    output logic                 M_STALL_O,
    output logic [NSLAVES-1:0]   S_STB_O,
    input  logic [NSLAVES*8-1:0] S_DAT_I,
    input  logic [NSLAVES-1:0]   S_ACK_I,
    input  logic [NSLAVES-1:0]   S_STALL_I,
    input  logic                 I_err_clr,
    output logic                 O_err,
    output logic                 O_err_multi,
    output logic [31:0]          O_err_adr
);

    localparam int IW = $clog2(NSLAVES + 1);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    wb8_state_e    r_state;
    logic [IW-1:0] r_sel;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_err_multi;
    logic [31:0]   r_err_adr;

    logic [IW-1:0] w_dec;
    logic          w_mapped;
    logic          w_req;
    logic [IW-1:0] w_sel;
    logic          w_route;
    logic          w_errack;
    logic          w_ack_s;
    logic          w_stall_s;
    logic [7:0]    w_dat_s;
    logic          w_tmo;
    logic          w_err_ev;

    wb8_addr_decode #(
        .NSLAVES       (NSLAVES),
        .SLAVE_BASE    (SLAVE_BASE),
        .SLAVE_MASK    (SLAVE_MASK),
        .DEFAULT_SLAVE (DEFAULT_SLAVE),
        .IW            (IW)
    ) u_dec (
        .i_adr    (M_ADR_I),
        .o_dec    (w_dec),
        .o_mapped (w_mapped)
    );

    assign w_req = M_CYC_I & M_STB_I;
    assign w_sel = (r_state == ST_IDLE) ? w_dec : r_sel;

    // Routing is live while a mapped request is presented in IDLE or a cycle is open.
    assign w_route = !RST_I &&
                     (((r_state == ST_IDLE) && w_req && w_mapped) ||
                      (r_state == ST_ACTIVE));
    assign w_errack = !RST_I && (r_state == ST_ERRACK);

    always_comb begin
        w_ack_s   = 1'b0;
        w_stall_s = 1'b0;
        w_dat_s   = 8'h00;
        for (int i = 0; i < NSLAVES; i++) begin
            if (w_sel == IW'(i)) begin
                w_ack_s   = S_ACK_I[i];
                w_stall_s = S_STALL_I[i];
                w_dat_s   = S_DAT_I[8*i +: 8];
            end
        end
    end

    always_comb begin
        S_STB_O = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            S_STB_O[i] = w_route && w_req && (w_sel == IW'(i));
        end
    end

    assign M_ACK_O   = w_errack | (w_route & w_ack_s);
    assign M_STALL_O = w_route & w_stall_s;
    assign M_DAT_O   = w_errack ? ERR_DATA : (w_route ? w_dat_s : 8'h00);

    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    assign w_err_ev = ((r_state == ST_IDLE) && w_req && !w_mapped) ||
                      ((r_state == ST_ACTIVE) && M_CYC_I && !w_ack_s && w_tmo);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_err_multi <= 1'b0;
            r_err_adr   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (!w_mapped) begin
                            r_state <= ST_ERRACK;
                        end else if (!w_ack_s) begin
                            r_sel   <= w_dec;
                            r_cnt   <= '0;
                            r_state <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_ack_s || !M_CYC_I) begin
                        r_state <= ST_IDLE;
                    end else if (w_tmo) begin
                        r_state <= ST_ERRACK;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_ERRACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A new fault outranks a same-cycle clear so it is never lost.
            if (w_err_ev) begin
                if (!r_err || I_err_clr) begin
                    r_err       <= 1'b1;
                    r_err_adr   <= M_ADR_I;
                    r_err_multi <= 1'b0;
                end else begin
                    r_err_multi <= 1'b1;
                end
            end else if (I_err_clr) begin
                r_err       <= 1'b0;
                r_err_multi <= 1'b0;
                r_err_adr   <= '0;
            end
        end
    end

    assign O_err       = r_err;
    assign O_err_multi = r_err_multi;
    assign O_err_adr   = r_err_adr;

endmodule
